// File: rtl/oled_pkg.sv
// oled_pkg: shared state encoding, SSD1306 command bases and glyph geometry for the glyph writer.
package oled_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_FETCH, ST_DATA, ST_FIN} state_t;
  localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
  localparam logic [7:0] CMD_COL_LO = 8'h00;
  localparam logic [7:0] CMD_COL_HI = 8'h10;
  localparam int GLYPH_W_NARROW = 8;
  localparam int GLYPH_W_WIDE = 16;
  localparam int FONT_IDX_W = 9;
  function automatic logic [7:0] page_cmd(input logic [2:0] pg, input logic row);
    logic [2:0] p;
    p = pg + {2'b00, row};
    return CMD_PAGE_BASE | {5'd0, p};
  endfunction
endpackage

// File: rtl/oled_byte_skid.sv
// oled_byte_skid: one-entry output register holding a byte until the transmitter accepts it.
module oled_byte_skid (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  logic       i_dc,
  input  logic       i_ready,
  output logic [7:0] o_byte,
  output logic       o_dc,
  output logic       o_valid
);
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      o_byte <= 8'd0;
      o_dc <= 1'b0;
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_byte <= i_byte;
      o_dc <= i_dc;
      o_valid <= 1'b1;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
endmodule

// File: rtl/oled_glyph_writer.sv
// oled_glyph_writer: reads a glyph from the font ROM and streams SSD1306 page/column commands plus data bytes.
// Optional OLED_GLYPH_INVERT_EN adds an invert input that complements data bytes.
module oled_glyph_writer
  import oled_pkg::*;
(
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            glyph_sel,
  input  logic                  glyph_wide,
  input  logic [2:0]            page,
  input  logic [6:0]            col,
`ifdef OLED_GLYPH_INVERT_EN
  input  logic                  invert,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [5:0]            font_sel,
  output logic                  font_row,
  output logic [FONT_IDX_W-1:0] index,
  input  logic [7:0]            font_data,
  output logic [7:0]            tx_byte,
  output logic                  tx_dc,
  output logic                  tx_valid,
  input  logic                  tx_ready
);
  state_t r_state, w_next;
  logic r_wide, r_row, r_inv;
  logic [2:0] r_page;
  logic [6:0] r_col;
  logic [1:0] r_cnt;
  logic w_hs, w_last, w_load, w_dc, w_inv_in;
  logic [7:0] w_byte, w_data;
`ifdef OLED_GLYPH_INVERT_EN
  assign w_inv_in = invert;
`else
  assign w_inv_in = 1'b0;
`endif
  assign w_hs = tx_valid & tx_ready;
  assign w_last = index == FONT_IDX_W'(r_wide ? GLYPH_W_WIDE - 1 : GLYPH_W_NARROW - 1);
  assign w_data = font_data ^ {8{r_inv}};
  assign busy = r_state != ST_IDLE;
  assign done = r_state == ST_FIN;
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_byte = w_data;
    w_dc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next = start ? ST_CMD : ST_IDLE;
        w_load = start;
        w_byte = page_cmd(page, 1'b0);
      end
      ST_CMD: begin
        w_next = (w_hs && r_cnt == 2'd2) ? ST_FETCH : ST_CMD;
        w_load = w_hs && r_cnt != 2'd2;
        w_byte = r_cnt == 2'd0 ? (CMD_COL_LO | {4'd0, r_col[3:0]}) : (CMD_COL_HI | {5'd0, r_col[6:4]});
      end
      ST_FETCH: begin
        w_next = r_cnt[0] ? ST_DATA : ST_FETCH;
        w_load = r_cnt[0];
        w_dc = 1'b1;
      end
      ST_DATA: begin
        w_next = !w_hs ? ST_DATA : !w_last ? ST_FETCH : !r_row ? ST_CMD : ST_FIN;
        w_load = w_hs && w_last && !r_row;
        w_byte = page_cmd(r_page, 1'b1);
      end
      ST_FIN: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_wide <= 1'b0;
      r_row <= 1'b0;
      r_inv <= 1'b0;
      r_page <= 3'd0;
      r_col <= 7'd0;
      r_cnt <= 2'd0;
      font_sel <= 6'd0;
      font_row <= 1'b0;
      index <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (start) begin
          font_sel <= glyph_sel;
          r_wide <= glyph_wide;
          r_page <= page;
          r_col <= col;
          r_inv <= w_inv_in;
          r_row <= 1'b0;
          r_cnt <= 2'd0;
        end
        ST_CMD: if (w_hs) begin
          r_cnt <= r_cnt == 2'd2 ? 2'd0 : r_cnt + 2'd1;
          if (r_cnt == 2'd2) begin
            font_row <= r_row;
            index <= '0;
          end
        end
        ST_FETCH: r_cnt <= r_cnt[0] ? 2'd0 : 2'd1;
        ST_DATA: if (w_hs) begin
          if (!w_last) index <= index + 1'b1;
          else r_row <= 1'b1;
        end
        default: ;
      endcase
    end
  oled_byte_skid u_skid (
    .sys_clk(sys_clk),
    .rst(rst),
    .i_load(w_load),
    .i_byte(w_byte),
    .i_dc(w_dc),
    .i_ready(tx_ready),
    .o_byte(tx_byte),
    .o_dc(tx_dc),
    .o_valid(tx_valid)
  );
endmodule

// File: tb/tb_oled_glyph_writer.sv
// tb_oled_glyph_writer: directed bench with a registered font ROM model and a handshake monitor.
module tb_oled_glyph_writer;
  logic sys_clk = 0, rst = 1, start = 0, glyph_wide = 0, invert = 0, tx_ready;
  logic [5:0] glyph_sel = 0;
  logic [2:0] page = 0;
  logic [6:0] col = 0;
  logic busy, done, font_row, tx_dc, tx_valid;
  logic [5:0] font_sel;
  logic [8:0] index;
  logic [7:0] font_data = 0, tx_byte;
  int checks = 0, errors = 0, dones = 0;
  int q[$];
  bit rnd = 0, pv = 0, pd;
  logic [7:0] pb;

  oled_glyph_writer dut (
    .sys_clk(sys_clk), .rst(rst), .start(start), .glyph_sel(glyph_sel),
    .glyph_wide(glyph_wide), .page(page), .col(col),
`ifdef OLED_GLYPH_INVERT_EN
    .invert(invert),
`endif
    .busy(busy), .done(done), .font_sel(font_sel), .font_row(font_row),
    .index(index), .font_data(font_data), .tx_byte(tx_byte), .tx_dc(tx_dc),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  initial forever #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) font_data <= {font_row, 2'b00, index[4:0]};
  initial forever begin
    @(posedge sys_clk);
    #1 tx_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (rst) pv = 0;
    else begin
      if (pv) begin
        chk("hold_valid", int'(tx_valid), 1);
        chk("hold_byte", {23'd0, tx_dc, tx_byte}, {23'd0, pd, pb});
      end
      if (tx_valid && tx_ready) q.push_back({23'd0, tx_dc, tx_byte});
      if (done) dones++;
      pv = tx_valid && !tx_ready;
      pb = tx_byte;
      pd = tx_dc;
    end
  end

  task automatic check_seq(input int base, input bit w, input int pg, input int c, input bit inv, input string tag);
    int n, k, e, wd;
    wd = w ? 16 : 8;
    n = 2 * (3 + wd);
    chk({tag, "_count"}, q.size() - base, n);
    k = base;
    for (int r = 0; r < 2; r++)
      for (int j = 0; j < 3 + wd; j++) begin
        e = j == 0 ? ('hB0 | ((pg + r) % 8)) : j == 1 ? (c & 15) : j == 2 ? ('h10 | (c >> 4))
            : ('h100 | ((((r << 7) | (j - 3)) ^ (inv ? 'hFF : 0)) & 'hFF));
        if (k < q.size()) chk({tag, "_byte"}, q[k], e);
        k++;
      end
  endtask

  task automatic run(input logic [5:0] sel, input bit w, input logic [2:0] pg, input logic [6:0] c,
                     input bit inv, input bit hammer, input string tag);
    int base, d0;
    base = q.size();
    d0 = dones;
    @(negedge sys_clk);
    glyph_sel = sel; glyph_wide = w; page = pg; col = c; invert = inv; start = 1;
    @(negedge sys_clk);
    chk({tag, "_first_valid"}, int'(tx_valid), 1);
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_font_sel"}, int'(font_sel), int'(sel));
    start = hammer;
    if (hammer) begin
      page = ~pg; glyph_wide = ~w; col = ~c; glyph_sel = ~sel;
    end
    for (int i = 0; i < 3000 && busy; i++) begin
      @(negedge sys_clk);
      if (done) start = 0;
    end
    start = 0;
    chk({tag, "_idle"}, int'(busy), 0);
    chk({tag, "_dones"}, dones - d0, 1);
    check_seq(base, w, int'(pg), int'(c), inv, tag);
  endtask

  initial begin
    int base, d0;
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(tx_valid), 0);
    chk("rst_outs", {tx_dc, tx_byte, font_sel, font_row, index, done}, 0);
    rst = 0;
    run(6'd12, 0, 3'd2, 7'h25, 0, 0, "narrow");
    run(6'd3, 1, 3'd7, 7'h00, 0, 0, "wide");
    rnd = 1;
    run(6'd12, 0, 3'd2, 7'h25, 0, 0, "bp");
    rnd = 0;
    run(6'd12, 0, 3'd2, 7'h25, 0, 1, "hammer");
    run(6'd9, 0, 3'd4, 7'h7A, 0, 0, "after");
    base = q.size();
    @(negedge sys_clk);
    glyph_sel = 6'd5; glyph_wide = 0; page = 3'd1; col = 7'h10; start = 1;
    @(negedge sys_clk);
    start = 0;
    for (int i = 0; i < 500 && q.size() - base < 10; i++) @(negedge sys_clk);
    chk("mid_progress", int'(q.size() - base >= 10), 1);
    @(posedge sys_clk);
    #2 rst = 1;
    #1 chk("mid_rst_outs", {busy, done, tx_valid, tx_dc, tx_byte, font_sel, font_row, index}, 0);
    d0 = dones;
    repeat (5) @(negedge sys_clk);
    chk("mid_rst_nodone", dones, d0);
    rst = 0;
    run(6'd12, 0, 3'd2, 7'h25, 0, 0, "post_rst");
`ifdef OLED_GLYPH_INVERT_EN
    run(6'd12, 0, 3'd2, 7'h25, 1, 0, "invert");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
